// File: rtl/base_tenc_pipe.sv
// ---------------------------------------------------------------------------
// base_tenc_pipe
//   Two-stage pipelined thermometer-to-binary encoder with valid/ready flow
//   control. Bit 0 of i_d is the first bit to fill. The output count is the
//   number of leading ones (the index of the first 0 bit), zero-extended to
//   enc_width, with o_d[0] as the MSB.
//
//   Optional feature macro: BASE_TENC_PIPE_ERR_EN
//     defined   : malformed codes (a 1 above the first 0) raise o_err with
//                 the beat, and o_err_sticky latches on the output accept of
//                 such a beat. i_err_clr clears the sticky flag, but a set in
//                 the same cycle wins.
//     undefined : o_err / o_err_sticky tie to 0 and i_err_clr is ignored.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   i_v / i_r    input valid / ready (i_r depends combinationally on o_r)
//   i_d          thermometer code [0:dec_width-1]
//   o_v / o_r    output valid / consumer ready
//   o_d          binary count [0:enc_width-1], MSB at index 0
//   o_err        malformed flag, qualified by o_v
//   o_err_sticky latched malformed flag
//   i_err_clr    clears o_err_sticky
// ---------------------------------------------------------------------------
module base_tenc_pipe #(
  parameter int dec_width = 8,
  parameter int enc_width = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_v,
  output logic                 i_r,
  input  logic [0:dec_width-1] i_d,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [0:enc_width-1] o_d,
  output logic                 o_err,
  output logic                 o_err_sticky,
  input  logic                 i_err_clr
);

  logic                 r_s1_v;
  logic [0:dec_width-1] r_s1_d;
  logic                 r_s2_v;
  logic [enc_width-1:0] r_s2_cnt;

  logic                 w_s2_ld;
  logic                 w_s1_ld;
  logic [enc_width-1:0] w_cnt;
  logic                 w_hit0;

  // No skid buffer: a stage may load whenever it is empty or its successor
  // takes its contents in the same cycle.
  assign w_s2_ld = ~r_s2_v | o_r;
  assign w_s1_ld = ~r_s1_v | w_s2_ld;
  assign i_r     = w_s1_ld;

  // Leading-ones count: stop counting at the first clear bit.
  always_comb begin
    w_cnt  = '0;
    w_hit0 = 1'b0;
    for (int unsigned i = 0; i < dec_width; i++) begin
      if (!r_s1_d[i]) begin
        w_hit0 = 1'b1;
      end else if (!w_hit0) begin
        w_cnt = w_cnt + enc_width'(1);
      end
    end
  end

  // Valid bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      if (w_s1_ld) r_s1_v <= i_v;
      if (w_s2_ld) r_s2_v <= r_s1_v;
    end
  end

  // Data registers carry no reset.
  always_ff @(posedge clk) begin
    if (w_s1_ld && i_v)    r_s1_d   <= i_d;
    if (w_s2_ld && r_s1_v) r_s2_cnt <= w_cnt;
  end

  assign o_v = r_s2_v;
  assign o_d = r_s2_cnt;

`ifdef BASE_TENC_PIPE_ERR_EN
  logic w_err;
  logic r_s2_err;
  logic r_sticky;

  // A 1 anywhere above the first 0 implies some 0->1 step between
  // neighbouring bits, so checking adjacent pairs is sufficient.
  always_comb begin
    w_err = 1'b0;
    for (int unsigned i = 1; i < dec_width; i++) begin
      if (r_s1_d[i] && !r_s1_d[i-1]) w_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s2_ld && r_s1_v) r_s2_err <= w_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= 1'b0;
    end else if (r_s2_v && o_r && r_s2_err) begin
      r_sticky <= 1'b1;
    end else if (i_err_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign o_err        = r_s2_err;
  assign o_err_sticky = r_sticky;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = i_err_clr;
  assign o_err            = 1'b0;
  assign o_err_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_base_tenc_pipe.sv
module tb_base_tenc_pipe;

  localparam int DW = 8;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_v;
  logic          i_r;
  logic [0:DW-1] i_d;
  logic          o_v;
  logic          o_r;
  logic [0:EW-1] o_d;
  logic          o_err;
  logic          o_err_sticky;
  logic          i_err_clr;

  int checks   = 0;
  int failures = 0;

  base_tenc_pipe #(.dec_width(DW), .enc_width(EW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_v          (i_v),
    .i_r          (i_r),
    .i_d          (i_d),
    .o_v          (o_v),
    .o_r          (o_r),
    .o_d          (o_d),
    .o_err        (o_err),
    .o_err_sticky (o_err_sticky),
    .i_err_clr    (i_err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: count = leading ones; malformed iff the code differs from
  // the canonical thermometer with that many leading ones.
  function automatic logic [31:0] therm(input int k);
    logic [0:DW-1] c;
    c = '0;
    for (int j = 0; j < k; j++) c[j] = 1'b1;
    return 32'(c);
  endfunction

  function automatic logic [31:0] ref_cnt(input logic [0:DW-1] c);
    int k;
    k = 0;
    while (k < DW && c[k]) k++;
    return 32'(k);
  endfunction

  function automatic logic ref_err(input logic [0:DW-1] c);
    return 32'(c) != therm(int'(ref_cnt(c)));
  endfunction

  // Scoreboard: {err, count}
  logic [32:0] sb_q[$];
  logic        prev_stall = 1'b0;
  logic [0:EW-1] prev_d;
  logic        prev_err;

  always @(negedge clk) begin
    logic [32:0] e;
    if (reset) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_v", 32'(o_v), 32'd1);
        chk("hold_d", 32'(o_d), 32'(prev_d));
        chk("hold_err", 32'(o_err), 32'(prev_err));
      end
      if (o_v && o_r) begin
        if (sb_q.size() == 0) begin
          chk("spurious_beat", 32'(o_d), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("sb_cnt", 32'(o_d), e[31:0]);
`ifdef BASE_TENC_PIPE_ERR_EN
          chk("sb_err", 32'(o_err), 32'(e[32]));
`else
          chk("sb_err_off", 32'(o_err), 32'd0);
`endif
        end
      end
      if (i_v && i_r) sb_q.push_back({ref_err(i_d), ref_cnt(i_d)});
      prev_stall = o_v && !o_r;
      prev_d     = o_d;
      prev_err   = o_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    i_v = 1'b0;
    o_r = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || o_v) && n < 50) begin
      tick();
      n++;
    end
    @(negedge clk);
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  logic [0:DW-1] sweep_code;

  initial begin
    reset = 1'b1; i_v = 1'b0; i_d = '0; o_r = 1'b1; i_err_clr = 1'b0;
    #1;
    chk("rst_o_v", 32'(o_v), 32'd0);
    chk("rst_i_r", 32'(i_r), 32'd1);
    chk("rst_sticky", 32'(o_err_sticky), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_o_v", 32'(o_v), 32'd0);
    chk("post_rst_i_r", 32'(i_r), 32'd1);

    // Sweep 0x00, 0x80, ... 0xFF back to back
    for (int c = 0; c < 11; c++) begin
      tick();
      if (c < 9) begin
        sweep_code = DW'(therm(c));
        i_v = 1'b1;
        i_d = sweep_code;
      end else begin
        i_v = 1'b0;
      end
      @(negedge clk);
      if (c >= 2) begin
        chk("sweep_v", 32'(o_v), 32'd1);
        chk("sweep_d", 32'(o_d), 32'(c - 2));
      end
    end
    drain("sweep_drain");

    // Backpressure: o_r low for 5 cycles while i_v=1
    for (int c = 0; c < 5; c++) begin
      tick();
      o_r = 1'b0;
      i_v = 1'b1;
      i_d = DW'(therm(c + 3));
      @(negedge clk);
      chk("bp_i_r", 32'(i_r), (c < 2) ? 32'd1 : 32'd0);
    end
    tick();
    o_r = 1'b1;
    i_v = 1'b0;
    @(negedge clk);
    chk("bp_release_i_r", 32'(i_r), 32'd1);
    drain("bp_drain");

    // Malformed code 0xA0
    tick();
    i_v = 1'b1;
    i_d = 8'hA0;
    tick();
    i_v = 1'b0;
    tick();
    @(negedge clk);
    chk("mal_v", 32'(o_v), 32'd1);
    chk("mal_d", 32'(o_d), 32'd1);
`ifdef BASE_TENC_PIPE_ERR_EN
    chk("mal_err", 32'(o_err), 32'd1);
    tick();
    @(negedge clk);
    chk("mal_sticky_set", 32'(o_err_sticky), 32'd1);
    tick();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    @(negedge clk);
    chk("mal_sticky_clr", 32'(o_err_sticky), 32'd0);
    // Clear coincident with a new malformed output accept: set wins
    i_v = 1'b1;
    i_d = 8'hA0;
    tick();
    i_v = 1'b0;
    tick();
    i_err_clr = 1'b1;
    @(negedge clk);
    chk("mal2_err", 32'(o_err), 32'd1);
    tick();
    i_err_clr = 1'b0;
    @(negedge clk);
    chk("mal_set_wins", 32'(o_err_sticky), 32'd1);
`else
    chk("mal_err_off", 32'(o_err), 32'd0);
    tick();
    @(negedge clk);
    chk("mal_sticky_off", 32'(o_err_sticky), 32'd0);
`endif
    drain("mal_drain");

    // Mid-flight reset
    tick();
    i_v = 1'b1;
    i_d = 8'hF0;
    tick();
    i_d = 8'hFF;
    tick();
    i_v = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_o_v", 32'(o_v), 32'd0);
    chk("midrst_sticky", 32'(o_err_sticky), 32'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_quiet", 32'(o_v), 32'd0);
      tick();
    end
    i_v = 1'b1;
    i_d = 8'hE0;
    tick();
    i_v = 1'b0;
    @(negedge clk);
    chk("fresh_v_early", 32'(o_v), 32'd0);
    tick();
    @(negedge clk);
    chk("fresh_v", 32'(o_v), 32'd1);
    chk("fresh_d", 32'(o_d), 32'd3);
    drain("fresh_drain");

    // Random traffic with valid codes
    for (int c = 0; c < 10000; c++) begin
      tick();
      i_v = 1'($urandom_range(0, 1));
      o_r = ($urandom_range(0, 3) != 0);
      i_d = DW'(therm(int'($urandom_range(0, DW))));
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/base_tenc_pipe.md
# base_tenc_pipe

Two-stage pipelined thermometer-to-binary encoder with valid/ready flow control, the inverse of the codebase's thermometer decoder. It accepts a left-justified thermometer code, where bits 0..k-1 are set and all others are clear, and returns the binary count k. It optionally flags malformed codes. It sits on request-slot and credit datapaths where occupancy masks are converted back to counts for counters and arbiters.

## Interface
- dec_width, 8, thermometer input width; must be ≥1
- enc_width, 4, binary output width; must satisfy 2^enc_width > dec_width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- i_v  input  1  input valid
- i_r  output  1  input ready
- i_d  input  [0:dec_width-1]  thermometer code; bit 0 is the first bit to fill
- o_v  output  1  output valid
- o_r  input  1  output ready from consumer
- o_d  output  [0:enc_width-1]  binary count, MSB at index 0
- o_err  output  1  malformed flag, qualified by o_v
- o_err_sticky  output  1  set by any accepted malformed code
- i_err_clr  input  1  clears o_err_sticky

## Operation
- A transfer occurs on each side when valid and ready are both high in the same cycle.
- Stage 1 (s1) registers i_d together with s1_v. Stage 2 (s2) registers the encoded count, the err bit, and s2_v. o_v is s2_v, o_d is the s2 count, and o_err is the s2 err bit.
- Advance rules:
  - s2 loads when ~s2_v | o_r.
  - s1 loads when ~s1_v | s2 loads.
  - i_r = ~s1_v | s2 loads. This is a combinational path from o_r to i_r. No skid buffer is used, so full throughput is one transfer per cycle.
- Encode: the count equals the number of leading ones, i.e. the index of the first 0 bit. An all-ones input gives dec_width. An all-zeros input gives 0. The result is zero-extended to enc_width.
- Malformed: any 1 bit at an index above the first 0 bit. For a malformed input, the count is still the leading-ones count.
- Sticky flag:
  - o_err_sticky sets on the cycle an s2 beat with err=1 is accepted by the consumer (o_v & o_r & o_err).
  - i_err_clr clears it.
  - If clear and set occur in the same cycle, set wins.
- Data registers need no reset. The valid bits and o_err_sticky reset to 0.

## Timing
- Reset values: o_v=0, o_err_sticky=0, i_r=1. o_d and o_err are don't-care while o_v=0. The bench must not check them then.
- Latency: a beat accepted on cycle N appears on o_v in cycle N+2 when there is no backpressure.
- Backpressure:
  - While o_r=0 and o_v=1, o_d and o_err hold stable.
  - With both stages full and o_r=0, i_r=0.
  - When o_r returns to 1, i_r=1 in the same cycle.
- Simultaneous events:
  - s2 draining while s1 refills is lossless.
  - An input accept in the same cycle as an output accept sustains one beat per cycle.
- Reset mid-operation: an asserted reset immediately clears both valid bits and the sticky flag, and discards in-flight beats. The first accept after reset deassertion follows the normal 2-cycle latency.
- Ordering is strictly FIFO. There is no reordering, no dropping, and no duplication.

## Configuration
- BASE_TENC_PIPE_ERR_EN:
  - Defined: malformed detection is compiled in as specified above.
  - Undefined: o_err and o_err_sticky are tied to 0, the detection logic is absent, and i_err_clr is ignored. Count and handshake behaviour are unchanged.

## Test plan
- Sweep: dec_width=8, enc_width=4; feed 0x00, 0x80, 0xC0, … 0xFF on back-to-back cycles with o_r=1. Required: o_d = 0,1,2,…,8 in order, each 2 cycles after its input, with o_v high continuously.
- Backpressure: drive o_r=0 for 5 cycles while i_v=1. Required: i_r falls after two accepts, o_d holds steady, and after o_r=1 every beat appears exactly once, in order.
- Malformed (macro on): input 0xA0 (1010_0000). Required: o_d=1, o_err=1, and o_err_sticky=1 the cycle after the output accept. Pulse i_err_clr; required: o_err_sticky=0. Assert i_err_clr together with a new malformed accept; required: o_err_sticky stays 1.
- Malformed (macro off): input 0xA0. Required: o_d=1, o_err=0, o_err_sticky=0.
- Mid-flight reset: accept 0xF0 and 0xFF, then assert reset before either reaches the output. Required: o_v=0 immediately and no beat emerges after reset release. A fresh 0xE0 yields o_d=3 two cycles after it is accepted.
- Random: random i_v/o_r with random valid codes for 10k cycles, checked against a scoreboard. Required: exact count match, in order, with no loss.
